// File: rtl/mod503_pkg.sv
// Shared constants, residue type and the single folding step used by the
// mod-503 reducer.
package mod503_pkg;

    localparam logic [8:0] MOD503 = 9'd503;
    localparam int         RES_W  = 9;

    typedef logic [RES_W-1:0] res_t;

    // One Horner step: returns (r * 512 + d) mod 503, using 512 == 9 (mod 503).
    function automatic res_t fold_step(input res_t r, input logic [8:0] d);
        logic [12:0] t;
        logic [9:0]  u;
        t = 13'(r) * 13'd9 + 13'(d);
        u = 10'(t[12:9]) * 10'd9 + 10'(t[8:0]);
        if (u >= 10'(MOD503)) begin
            u = u - 10'(MOD503);
        end
        return res_t'(u);
    endfunction

endpackage

// File: rtl/mod503_rr_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr,
// wrapping, produces a one-hot grant plus its encoded index.
module mod503_rr_arb #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             en,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_idx
);

    always_comb begin
        int   idx;
        logic found;
        // NOTE: every output gets a default before the search so no path through
        // this block leaves a value unassigned (which would infer a latch).
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (en && !found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = ID_W'(idx);
            end
        end
    end

endmodule

// File: rtl/x_500_mod_503.sv
// Combinational 500-bit mod-503 reducer: Horner evaluation over 9-bit digits,
// most significant (5-bit) digit first.
module x_500_mod_503
    import mod503_pkg::*;
(
    input  logic [499:0] din,
    output res_t         res
);

    always_comb begin
        res_t r;
        // The top 5 bits are already below 503, so they seed the accumulator.
        r = res_t'(din[499:495]);
        for (int i = 54; i >= 0; i--) begin
            r = fold_step(r, din[i*9 +: 9]);
        end
        res = r;
    end

endmodule

// File: rtl/mod503_share_arb.sv
// Shares one mod-503 reducer among N_REQ valid/ready requesters through a
// two-stage (operand, response) pipeline with response backpressure.
module mod503_share_arb
    import mod503_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W     = 500,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [N_REQ*W-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               rsp_valid,
    output logic [8:0]         rsp_data,
    output logic [ID_W-1:0]    rsp_id,
    input  logic               rsp_ready,
    output logic               busy
);

    logic [W-1:0]     op_q, op_d;
    logic [ID_W-1:0]  id0_q, id0_d;
    logic             v0_q, v0_d;
    res_t             rsp_data_q, rsp_data_d;
    logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;

    logic             s1_free;
    logic             s0_free;
    logic             arb_en;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             accept;
    res_t             red_res;

    assign s1_free = !rsp_valid_q || rsp_ready;
    assign s0_free = !v0_q || s1_free;
    // Gating with rst_n keeps req_ready low for the whole reset period.
    assign arb_en  = s0_free && rst_n;

    mod503_rr_arb #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr_q),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // The reducer sits only between op_q and the response register.
    x_500_mod_503 u_red (
        .din (op_q),
        .res (red_res)
    );

    assign req_ready = gnt;
    assign accept    = |(req_valid & gnt);

    always_comb begin
        op_d        = op_q;
        id0_d       = id0_q;
        v0_d        = v0_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        rr_ptr_d    = rr_ptr_q;

        if (s1_free) begin
            rsp_valid_d = v0_q;
            if (v0_q) begin
                rsp_data_d = red_res;
                rsp_id_d   = id0_q;
            end
        end

        if (s0_free) begin
            v0_d = accept;
            if (accept) begin
                op_d     = req_data[int'(gnt_idx)*W +: W];
                id0_d    = gnt_idx;
                rr_ptr_d = ID_W'((int'(gnt_idx) + 1) % N_REQ);
            end
        end
    end

    // NOTE: op_q is a wide datapath register but is still cleared on reset, so
    // nothing stale can ever reach the reducer output after reset.
    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so every flop samples
        // the pre-edge value of every other flop.
        if (!rst_n) begin
            op_q        <= '0;
            id0_q       <= '0;
            v0_q        <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
            rr_ptr_q    <= '0;
        end else begin
            op_q        <= op_d;
            id0_q       <= id0_d;
            v0_q        <= v0_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = v0_q || rsp_valid_q;

endmodule

// File: tb/tb_mod503_share_arb.sv
// Self-checking bench for mod503_share_arb: vector table, directed corner
// sequences and a randomized scoreboard against a FIFO-level reference model.
module tb_mod503_share_arb;

    localparam int N_REQ = 4;
    localparam int W     = 500;
    localparam int ID_W  = 2;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ*W-1:0] req_data;
    logic [N_REQ-1:0]   req_ready;
    logic               rsp_valid;
    logic [8:0]         rsp_data;
    logic [ID_W-1:0]    rsp_id;
    logic               rsp_ready;
    logic               busy;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mod503_share_arb #(
        .N_REQ (N_REQ),
        .W     (W),
        .ID_W  (ID_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    typedef struct {
        logic [3:0] valid;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_rv;
        logic [1:0] exp_id;
        logic [8:0] exp_data;
    } vec_t;

    typedef struct {
        int         id;
        logic [8:0] res;
        bit         st;
    } item_t;

    item_t      q[$];
    logic [W-1:0] pend[N_REQ];
    bit         pv[N_REQ];
    int         mptr;
    int         accepts;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [8:0] ref_res(input logic [W-1:0] v);
        logic [W-1:0] m;
        m = v % W'(503);
        return m[8:0];
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [511:0] t;
        int sel;
        sel = $urandom_range(0, 15);
        t = '0;
        if (sel == 0) t = '0;
        else if (sel == 1) t = 512'd503;
        else if (sel == 2) t = '1;
        else if (sel == 3) t = 512'($urandom_range(0, 2000));
        else begin
            for (int j = 0; j < 16; j++) t[j*32 +: 32] = $urandom;
        end
        return t[W-1:0];
    endfunction

    task automatic set_op(input int i, input logic [W-1:0] v);
        req_data[i*W +: W] = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One cycle: apply inputs, check at the falling edge, return 1 after the rising edge.
    task automatic cyc(input string name, input logic [3:0] v, input logic rr,
                       input logic [3:0] exp_rdy, input bit chk_rsp,
                       input logic exp_rv, input logic [1:0] exp_id, input logic [8:0] exp_data);
        req_valid = v;
        rsp_ready = rr;
        @(negedge clk);
        check({name, "_ready"}, 32'(req_ready), 32'(exp_rdy));
        if (chk_rsp) begin
            check({name, "_rv"}, 32'(rsp_valid), 32'(exp_rv));
            if (exp_rv) begin
                check({name, "_id"}, 32'(rsp_id), 32'(exp_id));
                check({name, "_data"}, 32'(rsp_data), 32'(exp_data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic single(input string name, input logic [W-1:0] op, input logic [8:0] exp);
        set_op(0, op);
        req_valid = 4'b0001;
        rsp_ready = 1'b1;
        @(negedge clk);
        check({name, "_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check({name, "_rv_early"}, 32'(rsp_valid), 32'd0);
        check({name, "_busy"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check({name, "_rv"}, 32'(rsp_valid), 32'd1);
        check({name, "_data"}, 32'(rsp_data), 32'(exp));
        check({name, "_id"}, 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // Reference model: the pipeline is a FIFO of at most two entries; the head
    // becomes visible one edge after it is the oldest and has spent an edge inside.
    task automatic rnd_cycle(input bit allow_new);
        int g;
        int idx;
        logic [3:0] exp_rdy;
        bit exp_rv;
        for (int i = 0; i < N_REQ; i++) begin
            if (allow_new && !pv[i] && $urandom_range(0, 3) != 0) begin
                pv[i] = 1'b1;
                pend[i] = rand_op();
            end
            req_valid[i] = pv[i];
            set_op(i, pend[i]);
        end
        rsp_ready = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        g = -1;
        if (q.size() < 2 || rsp_ready) begin
            for (int k = 0; k < N_REQ; k++) begin
                idx = (mptr + k) % N_REQ;
                if (g < 0 && pv[idx]) g = idx;
            end
        end
        exp_rdy = (g >= 0) ? 4'(1 << g) : 4'b0000;
        exp_rv = (q.size() > 0) && q[0].st;
        check("rnd_ready", 32'(req_ready), 32'(exp_rdy));
        check("rnd_rv", 32'(rsp_valid), 32'(exp_rv));
        check("rnd_busy", 32'(busy), 32'(q.size() > 0));
        if (exp_rv) begin
            check("rnd_id", 32'(rsp_id), 32'(q[0].id));
            check("rnd_data", 32'(rsp_data), 32'(q[0].res));
        end
        if (exp_rv && rsp_ready) void'(q.pop_front());
        if (q.size() > 0 && !q[0].st) q[0].st = 1'b1;
        if (g >= 0) begin
            q.push_back('{g, ref_res(pend[g]), 1'b0});
            pv[g] = 1'b0;
            mptr = (g + 1) % N_REQ;
            accepts++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[11];
        logic [W-1:0] v;
        int cycles;

        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0, 9'd0};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b0, 2'd0, 9'd0};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 9'd81};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 9'd81};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 2'd2, 9'd81};
        tbl[5]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 2'd3, 9'd81};
        tbl[6]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 2'd0, 9'd81};
        tbl[7]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 2'd1, 9'd81};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2, 9'd81};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3, 9'd81};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 9'd0};

        req_data = '0;
        req_valid = '0;
        rsp_ready = 1'b1;
        rst_n = 1'b0;

        // Reset state, with every requester asking during reset.
        req_valid = 4'b1111;
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        do_reset();
        @(negedge clk);
        check("reset_rv", 32'(rsp_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(rsp_data), 32'd0);
        check("reset_id", 32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;

        // Single operands from requester 0.
        single("single_503", W'(503), 9'd0);
        single("single_1011", W'(1011), 9'd5);
        v = W'(1) << 27;
        single("single_2p27", v, 9'd226);

        // Round-robin fairness from a fresh pointer, full pipeline still accepting.
        do_reset();
        for (int i = 0; i < N_REQ; i++) set_op(i, W'(1) << 18);
        for (int i = 0; i < 11; i++) begin
            cyc($sformatf("rr%0d", i), tbl[i].valid, tbl[i].rdy, tbl[i].exp_ready, 1'b1,
                tbl[i].exp_rv, tbl[i].exp_id, tbl[i].exp_data);
        end

        // Backpressure: two accepts then stall with stable response, drain 1 then 2.
        do_reset();
        set_op(1, W'(1011));
        set_op(2, W'(1000));
        cyc("bp0", 4'b0110, 1'b0, 4'b0010, 1'b1, 1'b0, 2'd0, 9'd0);
        cyc("bp1", 4'b0110, 1'b0, 4'b0100, 1'b1, 1'b0, 2'd0, 9'd0);
        cyc("bp2", 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 9'd5);
        cyc("bp3", 4'b0110, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd1, 9'd5);
        cyc("bp4", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd1, 9'd5);
        cyc("bp5", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd2, 9'd497);
        cyc("bp6", 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 2'd0, 9'd0);

        // Pointer wrap with sparse requests.
        do_reset();
        cyc("wrap0", 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 9'd0);
        cyc("wrap3", 4'b1000, 1'b1, 4'b1000, 1'b0, 1'b0, 2'd0, 9'd0);
        check("wrap_ptr", 32'(dut.rr_ptr_q), 32'd0);
        cyc("wrap0b", 4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 2'd0, 9'd0);
        cyc("wrap_all", 4'b1111, 1'b1, 4'b0010, 1'b0, 1'b0, 2'd0, 9'd0);

        // Reset with both stages full.
        do_reset();
        set_op(0, W'(1011));
        set_op(1, W'(1000));
        cyc("mid0", 4'b0011, 1'b0, 4'b0001, 1'b0, 1'b0, 2'd0, 9'd0);
        cyc("mid1", 4'b0011, 1'b0, 4'b0010, 1'b0, 1'b0, 2'd0, 9'd0);
        rst_n = 1'b0;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        @(negedge clk);
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_full_rv", 32'(rsp_valid), 32'd1);
        check("mid_full_data", 32'(rsp_data), 32'd5);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req_valid = '0;
        @(negedge clk);
        check("mid_rv", 32'(rsp_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_data", 32'(rsp_data), 32'd0);
        check("mid_ptr", 32'(dut.rr_ptr_q), 32'd0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("mid_stale_rv", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
        end

        // Randomized scoreboard.
        do_reset();
        q.delete();
        mptr = 0;
        accepts = 0;
        for (int i = 0; i < N_REQ; i++) begin
            pv[i] = 1'b0;
            pend[i] = '0;
        end
        cycles = 0;
        while (accepts < 10000 && cycles < 40000) begin
            rnd_cycle(1'b1);
            cycles++;
        end
        check("rnd_accept_count", 32'(accepts), 32'd10000);
        for (int c = 0; c < 20 && (q.size() > 0 || pv[0] || pv[1] || pv[2] || pv[3]); c++) begin
            rnd_cycle(1'b0);
        end
        check("rnd_drained", 32'(q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
